pipelined_addsub: RTL and testbench



---
 rtl/pipelined_addsub_pkg.sv | 13 +
 rtl/pipelined_addsub_chunk.sv | 28 ++
 rtl/pipelined_addsub.sv | 136 +++++++++++++
 tb/tb_pipelined_addsub.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
//   OP_ADD / OP_SUB : encoding of the in_op input
//   stage_count()   : number of pipeline stages for a given width and slice size
package pipelined_addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int stage_count(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/pipelined_addsub_chunk.sv
// Combinational CHUNK-bit slice adder used by every pipeline stage.
//   a_i, b_i : slice operands (b already inverted for subtraction)
//   cin_i    : carry into the slice
//   s_o      : slice sum
//   cout_o   : carry out of the slice MSB
//   cmsb_o   : carry into the slice MSB (signed-overflow detection in the top slice)
module addsub_chunk
    import pipelined_addsub_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] s_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [CHUNK:0] full;

    assign full   = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};
    assign s_o    = full[CHUNK-1:0];
    assign cout_o = full[CHUNK];
    // The carry into the MSB is recovered from the MSB sum bit and its operands.
    assign cmsb_o = a_i[CHUNK-1] ^ b_i[CHUNK-1] ^ full[CHUNK-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/subtract. The WIDTH-bit operation is split into
// CHUNK-bit slices, one slice per stage, with the carry registered between stages.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : operation handshake (in_ready = global advance enable)
//   in_a, in_b, in_op    : operands, 0 = add, 1 = subtract
//   out_valid/out_ready  : result handshake
//   out_s                : result modulo 2^WIDTH
//   out_cout             : carry out of MSB (subtract: 1 = no borrow)
//   out_ovf, out_zero    : signed overflow, result-is-zero
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int NSTAGE = stage_count(WIDTH, CHUNK);

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("pipelined_addsub: WIDTH must be a positive multiple of CHUNK");
    end

    // Per-stage operand vector: the low slice is the next chunk of a to process,
    // the high slices hold finished sum chunks. Each stage rotates its new sum in
    // at the top, so after NSTAGE stages the vector is the complete result.
    logic [WIDTH-1:0] stg_x [NSTAGE+1];
    // Remaining (already inverted) b, shifted down one slice per stage.
    logic [WIDTH-1:0] stg_b [NSTAGE];
    logic             stg_c [NSTAGE+1];
    logic             stg_v [NSTAGE+1];
    logic             en;

    assign en       = ~stg_v[NSTAGE] | out_ready;
    assign in_ready = en;

    assign stg_x[0] = in_a;
    assign stg_b[0] = (in_op == OP_SUB) ? ~in_b : in_b;
    assign stg_c[0] = (in_op == OP_SUB);
    assign stg_v[0] = in_valid;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        logic [CHUNK-1:0] sum;
        logic             cout;
        logic [WIDTH-1:0] x_d;
        logic [WIDTH-1:0] x_q;
        logic             c_q;
        logic             v_q;

        assign x_d = (stg_x[k] >> CHUNK) | (WIDTH'(sum) << (WIDTH - CHUNK));

        always_ff @(posedge clk) begin
            if (rst) begin
                x_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (en) begin
                x_q <= x_d;
                c_q <= cout;
                v_q <= stg_v[k];
            end
        end

        assign stg_x[k+1] = x_q;
        assign stg_c[k+1] = c_q;
        assign stg_v[k+1] = v_q;

        if (k < NSTAGE - 1) begin : g_mid
            logic             cmsb_unused;
            logic [WIDTH-1:0] b_q;

            addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
                .a_i    (stg_x[k][CHUNK-1:0]),
                .b_i    (stg_b[k][CHUNK-1:0]),
                .cin_i  (stg_c[k]),
                .s_o    (sum),
                .cout_o (cout),
                .cmsb_o (cmsb_unused)
            );

            always_ff @(posedge clk) begin
                if (rst) begin
                    b_q <= '0;
                end else if (en) begin
                    b_q <= stg_b[k] >> CHUNK;
                end
            end

            assign stg_b[k+1] = b_q;
        end else begin : g_last
            logic cmsb;
            logic ovf_q;
            logic zero_q;

            addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
                .a_i    (stg_x[k][CHUNK-1:0]),
                .b_i    (stg_b[k][CHUNK-1:0]),
                .cin_i  (stg_c[k]),
                .s_o    (sum),
                .cout_o (cout),
                .cmsb_o (cmsb)
            );

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (en) begin
                    ovf_q  <= cmsb ^ cout;
                    zero_q <= ~|x_d;
                end
            end

            assign out_ovf  = ovf_q;
            assign out_zero = zero_q;
        end
    end

    assign out_s     = stg_x[NSTAGE];
    assign out_cout  = stg_c[NSTAGE];
    assign out_valid = stg_v[NSTAGE];

endmodule

// File: tb/tb_pipelined_addsub.sv
module tb_pipelined_addsub;

    localparam int NOPS = 10000;
    localparam int NCFG = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference: {s[63:0], cout, ovf, zero} from plain integer arithmetic.
    function automatic logic [66:0] ref_model(input int w, input logic op,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [63:0]        mask;
        logic [63:0]        s;
        logic [64:0]        wide;
        logic signed [65:0] sa, sb, r, lim;
        logic               cout, ovf;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        s    = (op ? (a - b) : (a + b)) & mask;
        if (op) begin
            cout = (a >= b);
        end else begin
            wide = {1'b0, a} + {1'b0, b};
            cout = wide[w];
        end
        sa = $signed({2'b00, a});
        if (a[w-1]) sa = sa - (66'sd1 <<< w);
        sb = $signed({2'b00, b});
        if (b[w-1]) sb = sb - (66'sd1 <<< w);
        r   = op ? (sa - sb) : (sa + sb);
        lim = 66'sd1 <<< (w - 1);
        ovf = (r >= lim) || (r < -lim);
        return {s, cout, ovf, (s == 64'd0)};
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] mask;
        logic [63:0] msb;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        msb  = 64'd1 << (w - 1);
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return mask;
            3:       return msb;
            4:       return msb - 64'd1;
            default: return {$urandom, $urandom} & mask;
        endcase
    endfunction

    function automatic int cfg_w(input int g);
        case (g)
            0: return 32;
            1: return 32;
            2: return 24;
            default: return 64;
        endcase
    endfunction

    function automatic int cfg_c(input int g);
        case (g)
            0: return 8;
            1: return 32;
            2: return 8;
            default: return 16;
        endcase
    endfunction

    // ---------------- directed DUT, 32/8 ----------------
    logic        m_rst, m_in_valid, m_in_ready, m_in_op;
    logic        m_out_valid, m_out_ready, m_cout, m_ovf, m_zero;
    logic [31:0] m_a, m_b, m_s;

    pipelined_addsub #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk       (clk),
        .rst       (m_rst),
        .in_valid  (m_in_valid),
        .in_ready  (m_in_ready),
        .in_a      (m_a),
        .in_b      (m_b),
        .in_op     (m_in_op),
        .out_valid (m_out_valid),
        .out_ready (m_out_ready),
        .out_s     (m_s),
        .out_cout  (m_cout),
        .out_ovf   (m_ovf),
        .out_zero  (m_zero)
    );

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    // Called at posedge+1 with in_ready known high; returns edges until out_valid.
    task automatic run_one(input logic op, input logic [31:0] a, input logic [31:0] b,
                           output int lat);
        m_in_valid  = 1'b1;
        m_in_op     = op;
        m_a         = a;
        m_b         = b;
        m_out_ready = 1'b1;
        @(posedge clk); #1;
        m_in_valid = 1'b0;
        lat = 1;
        while (!m_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        vec_t        vt [7];
        vec_t        st [6];
        logic [66:0] sexp [6];
        int          lat, idx, got, seen, cyc;

        vt[0] = '{1'b1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
        vt[1] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vt[2] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vt[3] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vt[4] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vt[5] = '{1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1'b0};
        vt[6] = '{1'b1, 32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b0, 1'b1};

        st[0] = '{1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0, 1'b0, 1'b0, 1'b0};
        st[1] = '{1'b1, 32'h0000_000A, 32'h0000_0014, 32'h0, 1'b0, 1'b0, 1'b0};
        st[2] = '{1'b0, 32'hFFFF_0000, 32'h0001_0000, 32'h0, 1'b0, 1'b0, 1'b0};
        st[3] = '{1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0};
        st[4] = '{1'b0, 32'h4000_0000, 32'h4000_0000, 32'h0, 1'b0, 1'b0, 1'b0};
        st[5] = '{1'b1, 32'h0000_1234, 32'h0000_1234, 32'h0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++)
            sexp[i] = ref_model(32, st[i].op, 64'(st[i].a), 64'(st[i].b));

        m_rst = 1'b1; m_in_valid = 1'b0; m_out_ready = 1'b0;
        m_in_op = 1'b0; m_a = '0; m_b = '0;
        repeat (2) @(posedge clk);
        #1;
        m_rst = 1'b0;
        check("reset_out_valid", m_out_valid, 1'b0);
        check("reset_outputs", {m_s, m_cout, m_ovf, m_zero}, 35'd0);
        check("reset_in_ready", m_in_ready, 1'b1);

        // single operations: latency and flag boundaries
        for (int i = 0; i < 7; i++) begin
            run_one(vt[i].op, vt[i].a, vt[i].b, lat);
            check($sformatf("vec%0d_latency", i), lat, 4);
            check($sformatf("vec%0d_result", i), {m_s, m_cout, m_ovf, m_zero},
                  {vt[i].s, vt[i].cout, vt[i].ovf, vt[i].zero});
        end
        @(posedge clk); #1;

        // back-to-back stream with a three-cycle consumer stall
        idx = 0;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            m_out_ready = !(c >= 5 && c <= 7);
            m_in_valid  = (idx < 6);
            if (idx < 6) begin
                m_in_op = st[idx].op;
                m_a     = st[idx].a;
                m_b     = st[idx].b;
            end
            @(negedge clk);
            check($sformatf("stream_in_ready_c%0d", c), m_in_ready, (c < 5 || c > 7));
            if (m_out_valid) begin
                check($sformatf("stream_result%0d_c%0d", got, c),
                      {64'(m_s), m_cout, m_ovf, m_zero}, sexp[got]);
                if (m_out_ready) got++;
            end
            if (m_in_valid && m_in_ready) idx++;
            @(posedge clk); #1;
        end
        check("stream_count", got, 6);
        m_in_valid  = 1'b0;
        m_out_ready = 1'b1;
        @(posedge clk); #1;

        // reset with three operations in flight; a transfer in the reset cycle is ignored
        for (int i = 0; i < 3; i++) begin
            m_in_valid = 1'b1;
            m_in_op    = 1'b0;
            m_a        = 32'(i + 100);
            m_b        = 32'd7;
            @(posedge clk); #1;
        end
        m_rst = 1'b1;
        m_a   = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        m_rst      = 1'b0;
        m_in_valid = 1'b0;
        check("rst_flight_out_valid", m_out_valid, 1'b0);
        check("rst_flight_outputs", {m_s, m_cout, m_ovf, m_zero}, 35'd0);
        check("rst_flight_in_ready", m_in_ready, 1'b1);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (m_out_valid) seen++;
        end
        check("rst_flight_discarded", seen, 0);
        run_one(1'b1, 32'd100, 32'd58, lat);
        check("post_reset_latency", lat, 4);
        check("post_reset_result", {m_s, m_cout, m_ovf, m_zero},
              {32'd42, 1'b1, 1'b0, 1'b0});

        cyc = 0;
        while (n_done < NCFG && cyc < 80000) begin
            @(posedge clk);
            cyc++;
        end
        check("random_blocks_finished", n_done, NCFG);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // ---------------- random streams for several geometries ----------------
    for (genvar g = 0; g < NCFG; g++) begin : g_rnd
        localparam int W = cfg_w(g);
        localparam int C = cfg_c(g);

        logic         r_rst, r_in_valid, r_in_ready, r_in_op;
        logic         r_out_valid, r_out_ready, r_cout, r_ovf, r_zero;
        logic [W-1:0] r_a, r_b, r_s;

        pipelined_addsub #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk       (clk),
            .rst       (r_rst),
            .in_valid  (r_in_valid),
            .in_ready  (r_in_ready),
            .in_a      (r_a),
            .in_b      (r_b),
            .in_op     (r_in_op),
            .out_valid (r_out_valid),
            .out_ready (r_out_ready),
            .out_s     (r_s),
            .out_cout  (r_cout),
            .out_ovf   (r_ovf),
            .out_zero  (r_zero)
        );

        initial begin
            logic [66:0] expq [$];
            logic [66:0] e;
            logic [63:0] va, vb;
            int          sent, got, cyc;

            r_rst = 1'b1; r_in_valid = 1'b0; r_out_ready = 1'b0;
            r_in_op = 1'b0; r_a = '0; r_b = '0;
            repeat (2) @(posedge clk);
            #1;
            r_rst = 1'b0;
            sent = 0;
            got  = 0;
            cyc  = 0;
            while (got < NOPS && cyc < 60000) begin
                va          = pick(W);
                vb          = pick(W);
                r_in_valid  = (sent < NOPS) && ($urandom_range(0, 3) != 0);
                r_in_op     = 1'($urandom_range(0, 1));
                r_a         = W'(va);
                r_b         = W'(vb);
                r_out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (r_out_valid && r_out_ready) begin
                    if (expq.size() == 0) begin
                        check($sformatf("rnd%0d_unexpected_valid", g), r_out_valid, 1'b0);
                    end else begin
                        e = expq.pop_front();
                        check($sformatf("rnd%0d_op%0d", g, got),
                              {64'(r_s), r_cout, r_ovf, r_zero}, e);
                    end
                    got++;
                end
                if (r_in_valid && r_in_ready) begin
                    expq.push_back(ref_model(W, r_in_op, va, vb));
                    sent++;
                end
                @(posedge clk); #1;
                cyc++;
            end
            check($sformatf("rnd%0d_completed", g), got, NOPS);
            n_done++;
        end
    end

endmodule
